id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64: width of operand, immediate and write-back data.
REQ-002 Parameter CNTW, default 16: width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  decode slot holds a real instruction.
REQ-006 stall  input  1  downstream hold request; ID/EX contents must not advance.
REQ-007 flush  input  1  branch/jump squash of the decode slot.
REQ-008 rs1, rs2, rd  input  5 each  decode register indices.
REQ-009 readdata1, readdata2  input  XLEN each  register-file read data.
REQ-010 imm  input  XLEN  decoded immediate.
REQ-011 ctrl_in  input  8  control bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [6:5] alu_op, [7] branch.
REQ-012 wb_reg_write, wb_rd, wb_data  input  1/5/XLEN  write-back port that is writing the register file this cycle.
REQ-013 ex_valid  output  1  EX slot holds a real instruction.
REQ-014 ex_rs1, ex_rs2, ex_rd  output  5 each  latched indices.
REQ-015 ex_data1, ex_data2, ex_imm  output  XLEN each  latched operands and immediate.
REQ-016 ex_ctrl  output  8  latched control bits, same bit map as ctrl_in.
REQ-017 hazard_stall  output  1  combinational load-use stall to PC and IF/ID (hold upstream).
REQ-018 bubble_count  output  CNTW  number of bubbles inserted since reset.

Function
REQ-019 hazard_stall SHALL be 1 iff ex_valid & ex_ctrl[1] & ex_rd!=0 & id_valid & (ex_rd==rs1 | ex_rd==rs2), else 0.
REQ-020 Per rising edge, priority: reset > stall (hold all registers) > flush (bubble) > hazard_stall (bubble) > load.
REQ-021 Bubble: ex_valid=0, ex_ctrl=0; ex_rs1/ex_rs2/ex_rd=0; ex_data1/ex_data2/ex_imm=0.
REQ-022 Load: ex_valid<=id_valid; ex_ctrl<=id_valid ? ctrl_in : 0; indices and imm latched unchanged.
REQ-023 Operand select on load, per source s in {1,2}: rs_s==0 -> 0; else wb_reg_write & wb_rd==rs_s -> wb_data; else readdata_s.
REQ-024 The write-back bypass of REQ-023 SHALL apply even when wb_rd equals both rs1 and rs2 (both operands get wb_data).
REQ-025 Latency: one cycle from decode inputs to ex_* outputs; hazard_stall has zero latency.
REQ-026 bubble_count SHALL increment by 1 on each edge where a bubble is inserted by REQ-020 because of flush or hazard_stall with id_valid=1, and SHALL saturate at all-ones.
REQ-027 stall=1 SHALL freeze bubble_count and all ex_* outputs, regardless of flush or hazard_stall.
REQ-028 An EX-slot load with ex_rd==0 SHALL never raise hazard_stall.
REQ-029 flush and hazard_stall together SHALL insert exactly one bubble and increment bubble_count once.

Reset
REQ-030 On a rising edge with reset=1: all ex_* outputs 0, ex_valid 0, bubble_count 0; reset overrides stall and flush.
REQ-031 hazard_stall SHALL read 0 in the cycle following a reset edge (ex_valid=0).
REQ-032 reset asserted mid-hazard SHALL clear the pending stall; no bubble is counted on that edge.

Verification
REQ-033 Plain load: id_valid=1, rs1=8, readdata1=5, rs2=0, readdata2=77, imm=12, ctrl_in=8'h11 -> next cycle ex_data1=5, ex_data2=0, ex_imm=12, ex_ctrl=8'h11, ex_valid=1.
REQ-034 WB bypass: rs1=rs2=9, readdata=3, wb_reg_write=1, wb_rd=9, wb_data=40 -> ex_data1=ex_data2=40; same with wb_rd=0 and rs1=0 -> ex_data1=0.
REQ-035 Load-use: EX holds ld with rd=6 (ctrl[1]=1); decode rs2=6 -> hazard_stall=1 same cycle; next edge ex_valid=0, ex_ctrl=0, bubble_count=1; following cycle hazard_stall=0.
REQ-036 Stall precedence: stall=1 with flush=1 for 3 cycles -> ex_* and bubble_count unchanged throughout; stall release with flush=1 -> one bubble, count +1.
REQ-037 Saturation: drive 2^CNTW+2 flushes with id_valid=1 -> bubble_count stays all-ones; then reset=1 with stall=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with write-back bypass,
// detects load-use hazards combinationally and counts inserted bubbles.
module id_ex_stage #(
   parameter int XLEN = 64,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic            stall,
   input  logic            flush,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] readdata1,
   input  logic [XLEN-1:0] readdata2,
   input  logic [XLEN-1:0] imm,
   input  logic [7:0]      ctrl_in,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_data1,
   output logic [XLEN-1:0] ex_data2,
   output logic [XLEN-1:0] ex_imm,
   output logic [7:0]      ex_ctrl,
   output logic            hazard_stall,
   output logic [CNTW-1:0] bubble_count
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic            load_use;
   logic            insert_bubble;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   // A load in EX whose destination feeds the instruction in decode.
   assign load_use = ex_valid && ex_ctrl[1] && (ex_rd != 5'd0) && id_valid &&
                     ((ex_rd == rs1) || (ex_rd == rs2));
   assign hazard_stall  = load_use;
   assign insert_bubble = flush || load_use;

   // x0 reads as zero; a same-cycle register-file write wins over the stale read.
   assign op1 = (rs1 == 5'd0)                     ? '0      :
                (wb_reg_write && (wb_rd == rs1))  ? wb_data : readdata1;
   assign op2 = (rs2 == 5'd0)                     ? '0      :
                (wb_reg_write && (wb_rd == rs2))  ? wb_data : readdata2;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_data1     <= '0;
         ex_data2     <= '0;
         ex_imm       <= '0;
         ex_ctrl      <= '0;
         bubble_count <= '0;
      end else if (!stall) begin
         if (insert_bubble) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            if (id_valid && (bubble_count != CNT_MAX))
               bubble_count <= bubble_count + 1'b1;
         end else begin
            ex_valid <= id_valid;
            ex_rs1   <= rs1;
            ex_rs2   <= rs2;
            ex_rd    <= rd;
            ex_data1 <= op1;
            ex_data2 <= op2;
            ex_imm   <= imm;
            ex_ctrl  <= id_valid ? ctrl_in : 8'h00;
         end
      end
   end

endmodule
